// File: rtl/axi4_burst_ram_slave.sv
// AXI4 burst memory slave terminating full bursts into a single-clock RAM.
// Read and write channels run concurrently, at most one burst per direction.
// Optional feature: define AXI_RAM_WRAP_EN to accept WRAP bursts; when it is
// undefined, WRAP bursts complete with SLVERR, writes are dropped and reads
// return zero.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, one RAM write per W handshake
//   W_RESP | bvalid high until bready
// Read FSM
//   state  | meaning
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | RAM read into registered R channel, 1 beat/clk while rready
module axi4_burst_ram_slave #(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 128,
   parameter int ID_WIDTH   = 1,
   parameter int MEM_BYTES  = 65536
) (
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_areset,
   input  logic [ID_WIDTH-1:0]     s_axi_awid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [7:0]              s_axi_awlen,
   input  logic [2:0]              s_axi_awsize,
   input  logic [1:0]              s_axi_awburst,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                    s_axi_wlast,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [ID_WIDTH-1:0]     s_axi_bid,
   output logic [1:0]              s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ID_WIDTH-1:0]     s_axi_arid,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [7:0]              s_axi_arlen,
   input  logic [2:0]              s_axi_arsize,
   input  logic [1:0]              s_axi_arburst,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [ID_WIDTH-1:0]     s_axi_rid,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]              s_axi_rresp,
   output logic                    s_axi_rlast,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);

   localparam int STRB_W  = DATA_WIDTH / 8;
   localparam int LANE_AW = $clog2(STRB_W);
   localparam int MEM_AW  = $clog2(MEM_BYTES);
   localparam int DEPTH   = MEM_BYTES / STRB_W;
   localparam int IDX_W   = MEM_AW - LANE_AW;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_RAM_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // A burst is rejected as a whole for oversize beats, reserved burst types,
   // or a WRAP that is disabled or malformed (bad length or unaligned start).
   function automatic logic burst_bad(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [7:0] len,
                                      input logic [2:0] size,
                                      input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] sz_mask;
      logic                  wrap_ok;
      logic                  bad;
      sz_mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
      wrap_ok = ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15))
                && ((addr & sz_mask) == '0);
      bad = (int'(size) > LANE_AW);
      case (burst)
         2'b00, 2'b01: ;
         2'b10:   if (!(WRAP_EN && wrap_ok)) bad = 1'b1;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // FIXED holds, INCR steps by the beat size, WRAP steps within the
   // (len+1)*2^size aligned window.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                       input logic [7:0] len,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step;
      logic [ADDR_WIDTH-1:0] wmask;
      step  = ADDR_WIDTH'(1) << size;
      wmask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      case (burst)
         2'b00:   return addr;
         2'b10:   return (addr & ~wmask) | ((addr + step) & wmask);
         default: return addr + step;
      endcase
   endfunction

   w_state_t              w_state;
   logic [ID_WIDTH-1:0]   w_id;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_len;
   logic [2:0]            w_size;
   logic [1:0]            w_burst;
   logic [7:0]            w_beat;
   logic                  w_bad;
   logic                  w_slverr;
   logic                  w_decerr;

   r_state_t              r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_len;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic [7:0]            r_beat;
   logic                  r_bad;

   logic             w_fire;
   logic             w_last_beat;
   logic             w_oor;
   logic             w_slverr_nxt;
   logic             w_decerr_nxt;
   logic             mem_we;
   logic [IDX_W-1:0] w_idx;
   logic             r_oor;
   logic             r_last_beat;
   logic             r_en;
   logic [IDX_W-1:0] r_idx;

   assign w_fire       = s_axi_wvalid && s_axi_wready;
   assign w_last_beat  = (w_beat == w_len);
   assign w_oor        = |w_addr[ADDR_WIDTH-1:MEM_AW];
   assign w_slverr_nxt = w_slverr || w_bad || (s_axi_wlast != w_last_beat);
   assign w_decerr_nxt = w_decerr || w_oor;
   assign w_idx        = w_addr[MEM_AW-1:LANE_AW];
   // A beat landing in the same edge as reset is dropped with the burst.
   assign mem_we       = w_fire && !w_oor && !w_bad && !s_axi_areset;

   assign r_oor        = |r_addr[ADDR_WIDTH-1:MEM_AW];
   assign r_last_beat  = (r_beat == r_len);
   assign r_en         = !s_axi_rvalid || s_axi_rready;
   assign r_idx        = r_addr[MEM_AW-1:LANE_AW];

   // Byte-strobed RAM write; contents survive reset.
   always_ff @(posedge s_axi_aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
         end
      end
   end

   // Write channel FSM: AW capture, W beats, accumulated B response.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_bid     <= '0;
         w_id          <= '0;
         w_addr        <= '0;
         w_len         <= '0;
         w_size        <= '0;
         w_burst       <= '0;
         w_beat        <= '0;
         w_bad         <= 1'b0;
         w_slverr      <= 1'b0;
         w_decerr      <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: begin
               s_axi_awready <= 1'b1;
               if (s_axi_awvalid && s_axi_awready) begin
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b1;
                  w_id          <= s_axi_awid;
                  w_addr        <= s_axi_awaddr;
                  w_len         <= s_axi_awlen;
                  w_size        <= s_axi_awsize;
                  w_burst       <= s_axi_awburst;
                  w_beat        <= '0;
                  w_bad         <= burst_bad(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
                  w_slverr      <= 1'b0;
                  w_decerr      <= 1'b0;
                  w_state       <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_slverr <= w_slverr_nxt;
                  w_decerr <= w_decerr_nxt;
                  w_addr   <= next_addr(w_addr, w_len, w_size, w_burst);
                  if (w_last_beat) begin
                     s_axi_wready <= 1'b0;
                     s_axi_bvalid <= 1'b1;
                     s_axi_bid    <= w_id;
                     s_axi_bresp  <= w_decerr_nxt ? RESP_DECERR :
                                     w_slverr_nxt ? RESP_SLVERR : RESP_OKAY;
                     w_state      <= W_RESP;
                  end else begin
                     w_beat <= w_beat + 8'd1;
                  end
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid  <= 1'b0;
                  s_axi_awready <= 1'b1;
                  w_state       <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   // Read channel FSM: registered RAM read, advances only when the output
   // register is empty or being consumed so data holds under backpressure.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rlast   <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rid     <= '0;
         r_addr        <= '0;
         r_len         <= '0;
         r_size        <= '0;
         r_burst       <= '0;
         r_beat        <= '0;
         r_bad         <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               s_axi_arready <= 1'b1;
               if (s_axi_arvalid && s_axi_arready) begin
                  s_axi_arready <= 1'b0;
                  s_axi_rid     <= s_axi_arid;
                  r_addr        <= s_axi_araddr;
                  r_len         <= s_axi_arlen;
                  r_size        <= s_axi_arsize;
                  r_burst       <= s_axi_arburst;
                  r_beat        <= '0;
                  r_bad         <= burst_bad(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
                  r_state       <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_en) begin
                  if (s_axi_rvalid && s_axi_rlast) begin
                     s_axi_rvalid  <= 1'b0;
                     s_axi_rlast   <= 1'b0;
                     s_axi_arready <= 1'b1;
                     r_state       <= R_IDLE;
                  end else begin
                     s_axi_rvalid <= 1'b1;
                     s_axi_rlast  <= r_last_beat;
                     s_axi_rdata  <= (r_oor || r_bad) ? '0 : mem[r_idx];
                     s_axi_rresp  <= r_oor ? RESP_DECERR :
                                     r_bad ? RESP_SLVERR : RESP_OKAY;
                     r_addr       <= next_addr(r_addr, r_len, r_size, r_burst);
                     if (!r_last_beat) r_beat <= r_beat + 8'd1;
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_burst_ram_slave.sv
// Directed bench for axi4_burst_ram_slave: INCR/FIXED/WRAP bursts, strobes,
// DECERR/SLVERR responses, read backpressure and mid-burst reset.
module tb_axi4_burst_ram_slave;

   localparam int BUDGET = 200;

   logic         clk = 1'b0;
   logic         areset;
   logic [0:0]   awid;
   logic [27:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic [1:0]   awburst;
   logic         awvalid;
   logic         awready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [0:0]   bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;
   logic [0:0]   arid;
   logic [27:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [0:0]   rid;
   logic [127:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   axi4_burst_ram_slave dut (
      .s_axi_aclk(clk), .s_axi_areset(areset),
      .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
      .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awvalid(awvalid),
      .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
      .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
      .s_axi_arready(arready),
      .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
      .s_axi_rvalid(rvalid), .s_axi_rready(rready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errs   = 0;
   int checks = 0;

   logic [127:0] wr_data [0:15];
   logic [15:0]  wr_strb;
   logic [1:0]   got_bresp;
   logic [0:0]   got_bid;
   logic [127:0] rd_data [0:15];
   logic [1:0]   rd_resp [0:15];
   logic         rd_last [0:15];
   logic [0:0]   rd_id;
   int           rd_n;
   int           rd_lat;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [0:0] id, input logic [27:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int nsend, input bit no_last);
      logic got;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < BUDGET && !got; t++) begin
         @(negedge clk); got = awready;
      end
      if (!got) chk("aw_timeout", 0, 1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int i = 0; i < nsend; i++) begin
         wdata = wr_data[i]; wstrb = wr_strb; wlast = !no_last && (i == int'(len)); wvalid = 1'b1;
         got = 1'b0;
         for (int t = 0; t < BUDGET && !got; t++) begin
            @(negedge clk); got = wready;
         end
         if (!got) chk("w_timeout", 0, 1);
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      if (nsend == int'(len) + 1) begin
         bready = 1'b1;
         got = 1'b0;
         for (int t = 0; t < BUDGET && !got; t++) begin
            @(negedge clk); got = bvalid;
         end
         if (!got) chk("b_timeout", 0, 1);
         got_bresp = bresp; got_bid = bid;
         @(posedge clk); #1;
         bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [0:0] id, input logic [27:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] pat);
      logic         got;
      logic         done;
      logic         stall;
      logic [127:0] hold;
      int           hs_cyc;
      int           first;
      int           k;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < BUDGET && !got; t++) begin
         @(negedge clk); got = arready;
      end
      if (!got) chk("ar_timeout", 0, 1);
      @(posedge clk); #1;
      hs_cyc = cyc;
      arvalid = 1'b0;
      rd_n = 0; done = 1'b0; stall = 1'b0; hold = '0; first = -1; k = 0;
      for (int t = 0; t < BUDGET && !done; t++) begin
         rready = pat[k % 4]; k++;
         @(negedge clk);
         if (rvalid) begin
            if (first < 0) first = cyc;
            if (stall) chk("r_hold", rdata, hold);
            if (rready) begin
               rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast; rd_id = rid;
               rd_n++;
               if (rlast || rd_n == 16) done = 1'b1;
            end
            stall = !rready; hold = rdata;
         end
         @(posedge clk); #1;
      end
      rready = 1'b0;
      if (!done) chk("r_timeout", 0, 1);
      rd_lat = first - hs_cyc + 1;
   endtask

   task automatic chk_read(input string tag, input int nexp, input logic [1:0] resp);
      chk({tag, "_beats"}, 128'(rd_n), 128'(nexp));
      for (int i = 0; i < nexp && i < rd_n; i++) begin
         chk($sformatf("%s_data%0d", tag, i), rd_data[i], wr_data[i]);
         chk($sformatf("%s_resp%0d", tag, i), 128'(rd_resp[i]), 128'(resp));
         chk($sformatf("%s_last%0d", tag, i), 128'(rd_last[i]), 128'(i == nexp - 1));
      end
   endtask

   initial begin
      areset = 1'b1;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      rready = 1'b0;
      wr_strb = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", 128'(awready), 0);
      chk("rst_arready", 128'(arready), 0);
      chk("rst_wready", 128'(wready), 0);
      chk("rst_bvalid", 128'(bvalid), 0);
      chk("rst_rvalid", 128'(rvalid), 0);
      chk("rst_rlast", 128'(rlast), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resp", 128'({bresp, rresp, bid, rid}), 0);
      areset = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_awready", 128'(awready), 1);
      chk("post_rst_arready", 128'(arready), 1);

      // INCR write/read 0x100, 4 beats
      for (int i = 0; i < 4; i++) wr_data[i] = 128'hA0 + 128'(i);
      axi_write(1'b1, 28'h100, 8'd3, 3'd4, 2'b01, 4, 1'b0);
      chk("incr_bresp", 128'(got_bresp), 0);
      chk("incr_bid", 128'(got_bid), 1);
      axi_read(1'b1, 28'h100, 8'd3, 3'd4, 2'b01, 4'b1111);
      chk_read("incr_rd", 4, 2'b00);
      chk("incr_rid", 128'(rd_id), 1);
      chk("incr_latency", 128'(rd_lat), 2);

      // Strobed write over an all-ones word
      wr_data[0] = '1;
      axi_write(1'b0, 28'h200, 8'd0, 3'd4, 2'b01, 1, 1'b0);
      wr_data[0] = 128'h0123456789abcdef_fedcba9876543210;
      wr_strb = 16'h000F;
      axi_write(1'b0, 28'h200, 8'd0, 3'd4, 2'b01, 1, 1'b0);
      wr_strb = '1;
      chk("strb_bresp", 128'(got_bresp), 0);
      wr_data[0] = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h76543210};
      axi_read(1'b0, 28'h200, 8'd0, 3'd4, 2'b01, 4'b1111);
      chk_read("strb_rd", 1, 2'b00);

      // DECERR beyond the RAM; word 0 (alias of 0x10000) must be untouched
      wr_data[0] = 128'h55;
      axi_write(1'b0, 28'h0, 8'd0, 3'd4, 2'b01, 1, 1'b0);
      wr_data[0] = 128'hDEAD; wr_data[1] = 128'hBEEF;
      axi_write(1'b0, 28'h10000, 8'd1, 3'd4, 2'b01, 2, 1'b0);
      chk("dec_bresp", 128'(got_bresp), 3);
      wr_data[0] = 128'h55;
      axi_read(1'b0, 28'h0, 8'd0, 3'd4, 2'b01, 4'b1111);
      chk_read("dec_alias", 1, 2'b00);
      wr_data[0] = '0; wr_data[1] = '0;
      axi_read(1'b0, 28'h10000, 8'd1, 3'd4, 2'b01, 4'b1111);
      chk_read("dec_rd", 2, 2'b11);

      // 8-beat read with rready pattern 1,0,0,1
      for (int i = 0; i < 8; i++) wr_data[i] = 128'hC0 + 128'(i);
      axi_write(1'b0, 28'h300, 8'd7, 3'd4, 2'b01, 8, 1'b0);
      chk("bp_bresp", 128'(got_bresp), 0);
      axi_read(1'b1, 28'h300, 8'd7, 3'd4, 2'b01, 4'b1001);
      chk_read("bp_rd", 8, 2'b00);

      // Missing wlast: SLVERR but data still stored
      wr_data[0] = 128'h61; wr_data[1] = 128'h62;
      axi_write(1'b0, 28'h600, 8'd1, 3'd4, 2'b01, 2, 1'b1);
      chk("wlast_bresp", 128'(got_bresp), 2);
      axi_read(1'b0, 28'h600, 8'd1, 3'd4, 2'b01, 4'b1111);
      chk_read("wlast_rd", 2, 2'b00);

      // FIXED burst: both beats land on the same word
      wr_data[0] = 128'h71; wr_data[1] = 128'h72;
      axi_write(1'b0, 28'h700, 8'd1, 3'd4, 2'b00, 2, 1'b0);
      chk("fixed_bresp", 128'(got_bresp), 0);
      wr_data[0] = 128'h72;
      axi_read(1'b0, 28'h700, 8'd0, 3'd4, 2'b01, 4'b1111);
      chk_read("fixed_rd", 1, 2'b00);

      // Reset after beat 2 of an 8-beat write
      for (int i = 0; i < 8; i++) wr_data[i] = 128'hD0 + 128'(i);
      axi_write(1'b0, 28'h400, 8'd7, 3'd4, 2'b01, 3, 1'b0);
      areset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_ready", 128'({awready, wready, arready}), 0);
      chk("midrst_valid", 128'({bvalid, rvalid}), 0);
      areset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_awready", 128'(awready), 1);
      wr_data[0] = 128'h51; wr_data[1] = 128'h52;
      axi_write(1'b1, 28'h500, 8'd1, 3'd4, 2'b01, 2, 1'b0);
      chk("midrst_bresp", 128'(got_bresp), 0);
      chk("midrst_bid", 128'(got_bid), 1);
      axi_read(1'b0, 28'h500, 8'd1, 3'd4, 2'b01, 4'b1111);
      chk_read("midrst_rd", 2, 2'b00);

      // WRAP len 3 from 0x130 over the A0..A3 block at 0x100
      for (int i = 0; i < 4; i++) wr_data[i] = 128'hE0 + 128'(i);
      axi_write(1'b0, 28'h130, 8'd3, 3'd4, 2'b10, 4, 1'b0);
`ifdef AXI_RAM_WRAP_EN
      chk("wrap_bresp", 128'(got_bresp), 0);
      axi_read(1'b0, 28'h130, 8'd3, 3'd4, 2'b10, 4'b1111);
      chk_read("wrap_rd", 4, 2'b00);
      wr_data[0] = 128'hE1; wr_data[1] = 128'hE2; wr_data[2] = 128'hE3; wr_data[3] = 128'hE0;
      axi_read(1'b0, 28'h100, 8'd3, 3'd4, 2'b01, 4'b1111);
      chk_read("wrap_incr_rd", 4, 2'b00);
`else
      chk("wrap_bresp", 128'(got_bresp), 2);
      for (int i = 0; i < 4; i++) wr_data[i] = '0;
      axi_read(1'b0, 28'h130, 8'd3, 3'd4, 2'b10, 4'b1111);
      chk_read("wrap_rd", 4, 2'b10);
      for (int i = 0; i < 4; i++) wr_data[i] = 128'hA0 + 128'(i);
      axi_read(1'b0, 28'h100, 8'd3, 3'd4, 2'b01, 4'b1111);
      chk_read("wrap_incr_rd", 4, 2'b00);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/axi4_burst_ram_slave.md
Name: axi4_burst_ram_slave

Overview:
- AXI4 memory slave placed directly downstream of the AXI clock-converter m_axi port, in the converter's master clock domain.
- Terminates full AXI4 bursts into an on-chip single-clock RAM: 128-bit data, 28-bit address, 1-bit ID.
- Read and write channels run independently and concurrently; at most one burst in flight per direction.

Parameters:
- ADDR_WIDTH, 28, AXI address width.
- DATA_WIDTH, 128, data width; power of 2, at least 32.
- ID_WIDTH, 1, AXI ID width.
- MEM_BYTES, 65536, RAM size in bytes; power of 2; depth = MEM_BYTES/(DATA_WIDTH/8).

Ports:
s_axi_aclk  in  1  sole clock
s_axi_areset  in  1  synchronous, active-high reset
s_axi_awid  in  ID_WIDTH  write burst ID
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes/beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_WIDTH  = captured awid
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  ID_WIDTH  read burst ID
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen  in  8  beats-1
s_axi_arsize  in  3  log2 bytes/beat
s_axi_arburst  in  2  burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  = captured arid
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Clocking/reset: one clock, s_axi_aclk. Reset is s_axi_areset, synchronous and active-high.
- Reset values: all ready/valid outputs 0; rlast 0; rdata, rresp, bresp, bid, rid all 0.
- Reset mid-burst: both FSMs return to IDLE and the in-flight burst is dropped. RAM contents are retained.
- awready and arready rise in the first cycle after reset deasserts.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, capture id/addr/len/size/burst, clear beat counter and error flags.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes at word addr[log2(MEM_BYTES)-1:log2(DATA_WIDTH/8)], then advances the address. After beat len, go to W_RESP.
  - W_RESP: bvalid=1 until bready; then W_IDLE. Earliest next AW is the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, capture the request.
  - R_DATA: synchronous RAM read, registered output. AR handshake in cycle T gives first rvalid in T+2.
  - RAM read enable = !rvalid || rready, so data holds stable under backpressure.
  - Throughput is 1 beat/clk while rready=1. rlast=1 on beat len. After the final handshake, return to R_IDLE.
- Address update per beat:
  - INCR: addr += 2^size.
  - FIXED: addr unchanged.
  - 4 KB boundary crossing is the master's responsibility and is not checked.
  - size greater than log2(DATA_WIDTH/8) is an error (SLVERR).
- Responses:
  - Beat address >= MEM_BYTES: DECERR. Write beat suppressed; read data 0.
  - Write wlast != (beat==len): SLVERR; data still written.
  - bresp = worst error seen in the burst, priority DECERR > SLVERR > OKAY.
  - rresp is per beat.
- Simultaneous read and write to the same word in one cycle: read returns old data (read-first).
- Burst length 1 (len=0): single beat, wlast/rlast required/asserted on beat 0.
- Maximum burst is 256 beats; the beat counter is 8 bits and must not overflow.

Optional Feature:
- AXI_RAM_WRAP_EN defined:
  - WRAP bursts supported. Wrap boundary = (len+1)*2^size bytes, aligned.
  - len must be 1, 3, 7 or 15 and start address must be size-aligned; otherwise the burst returns SLVERR.
- Undefined:
  - WRAP bursts return SLVERR on every beat and B; writes are discarded, read data is 0.
  - All handshake counts are unchanged.

Test Plan:
- INCR write, addr 0x100, len 3, size 4, data 0xA0..0xA3, full strobes -> bresp OKAY, bid = awid. INCR read of the same range -> 4 beats 0xA0..0xA3, rlast on beat 3, first rvalid 2 cycles after AR handshake.
- Strobed write: wstrb 0x000F over 0xFFFF.. word -> readback has only low 4 bytes updated.
- Write to addr MEM_BYTES, len 1 -> bresp DECERR, RAM untouched. Read of the same address -> 2 beats, rdata 0, rresp DECERR each beat.
- Read len 7 with rready toggling 1,0,0,1 -> no beat lost or duplicated; rdata stable while rvalid & !rready.
- Reset asserted mid write burst (after beat 2 of 8) -> next cycle all valids/readys 0, then awready=1. New burst completes with OKAY.
- WRAP, len 3, size 4, addr 0x130 -> with macro: beats at 0x130, 0x100, 0x110, 0x120, OKAY. Without macro: SLVERR on every beat.
